// File: rtl/paddle_adc_pkg.sv
// Shared types and helpers for the paddle potentiometer ADC sampler.
package paddle_adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } adc_state_t;

  localparam int ADC_FRAME_BITS  = 16;
  localparam int ADC_RESULT_BITS = 10;
  localparam int SAMPLE_BITS     = 8;

  // MCP3002 command word, MSB first: pad, start, single-ended, odd/sign, MSBF, then don't-care.
  function automatic logic [ADC_FRAME_BITS-1:0] adc_cmd(input logic channel);
    return {1'b0, 1'b1, 1'b1, channel, 1'b1, 11'b0};
  endfunction

endpackage

// File: rtl/paddle_adc_sampler_if.sv
// SPI pins toward the ADC plus the sample stream toward the paddle filters.
interface paddle_adc_sampler_if;
  import paddle_adc_pkg::*;

  logic                   adc_cs_n;
  logic                   adc_sclk;
  logic                   adc_mosi;
  logic                   adc_miso;
  logic [SAMPLE_BITS-1:0] sample;
  logic                   sample_ch;
  logic                   sample_latch;

  modport master (
    output adc_cs_n, adc_sclk, adc_mosi, sample, sample_ch, sample_latch,
    input  adc_miso
  );

  modport slave (
    input  adc_cs_n, adc_sclk, adc_mosi, sample, sample_ch, sample_latch,
    output adc_miso
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchroniser, clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to settle metastability from the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/paddle_adc_sampler.sv
// Periodic round-robin SPI reader for the paddle potentiometer ADC.
//
// state | meaning
// IDLE  | waiting for the period counter to wrap
// SETUP | CS low, first command bit on MOSI, SCLK low
// SHIFT | 16 SCLK periods, command out on MOSI, result in from MISO
// HOLD  | CS still low, SCLK low, before releasing CS
// DONE  | publish the sample and advance the channel
module paddle_adc_sampler
  import paddle_adc_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2048,
  parameter int NUM_CHANNELS  = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  paddle_adc_sampler_if.master  bus
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int PER_W = $clog2(SAMPLE_PERIOD);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);

  if (CLK_DIV < 3) begin : g_bad_clk_div
    $error("paddle_adc_sampler: CLK_DIV must be >= 3");
  end
  if (SAMPLE_PERIOD <= CLK_DIV * 34 + 2) begin : g_bad_period
    $error("paddle_adc_sampler: SAMPLE_PERIOD shorter than a conversion");
  end
  if (NUM_CHANNELS < 1 || NUM_CHANNELS > 2) begin : g_bad_channels
    $error("paddle_adc_sampler: NUM_CHANNELS must be 1 or 2");
  end

  adc_state_t                 state;
  logic [PER_W-1:0]           per_cnt;
  logic [DIV_W-1:0]           div_cnt;
  logic [3:0]                 bit_idx;
  logic                       sclk_high;
  logic [ADC_RESULT_BITS-1:0] shreg;
  logic                       channel;
  logic                       miso_sync;
  logic [ADC_FRAME_BITS-1:0]  cmd;

  assign cmd = adc_cmd(channel);

  sync_2ff u_miso_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (bus.adc_miso),
    .q     (miso_sync)
  );

  // Free-running conversion period counter; a frame starts when it reads 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      per_cnt <= '0;
    end else if (per_cnt == PER_LAST) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // Frame sequencer with registered SPI pins and sample outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      div_cnt          <= '0;
      bit_idx          <= '0;
      sclk_high        <= 1'b0;
      shreg            <= '0;
      channel          <= 1'b0;
      bus.adc_cs_n     <= 1'b1;
      bus.adc_sclk     <= 1'b0;
      bus.adc_mosi     <= 1'b0;
      bus.sample       <= '0;
      bus.sample_ch    <= 1'b0;
      bus.sample_latch <= 1'b0;
    end else begin
      bus.sample_latch <= 1'b0;
      case (state)
        IDLE: begin
          if (per_cnt == '0) begin
            state        <= SETUP;
            div_cnt      <= '0;
            bus.adc_cs_n <= 1'b0;
            bus.adc_sclk <= 1'b0;
            bus.adc_mosi <= cmd[ADC_FRAME_BITS-1];
          end
        end
        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            state     <= SHIFT;
            div_cnt   <= '0;
            bit_idx   <= 4'(ADC_FRAME_BITS - 1);
            sclk_high <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!sclk_high) begin
              sclk_high    <= 1'b1;
              bus.adc_sclk <= 1'b1;
            end else begin
              // Capture at the very end of the high phase, then fall into the next bit.
              sclk_high    <= 1'b0;
              bus.adc_sclk <= 1'b0;
              shreg        <= {shreg[ADC_RESULT_BITS-2:0], miso_sync};
              if (bit_idx == 4'd0) begin
                state <= HOLD;
              end else begin
                bit_idx      <= bit_idx - 4'd1;
                bus.adc_mosi <= cmd[bit_idx - 4'd1];
              end
            end
          end
        end
        HOLD: begin
          if (div_cnt == DIV_LAST) begin
            state        <= DONE;
            div_cnt      <= '0;
            bus.adc_cs_n <= 1'b1;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        DONE: begin
          state            <= IDLE;
          bus.sample       <= shreg[ADC_RESULT_BITS-1:ADC_RESULT_BITS-SAMPLE_BITS];
          bus.sample_ch    <= channel;
          bus.sample_latch <= 1'b1;
          channel          <= (NUM_CHANNELS == 1) ? 1'b0 : ~channel;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
